// File: rtl/seg7_pkg.sv
// Shared character codes, segment lookup table and the panel message ROM
// for the time-multiplexed 7-segment message scanner.
package seg7_pkg;

   typedef logic [4:0] char_t;

   localparam char_t CH_0     = 5'd0;
   localparam char_t CH_1     = 5'd1;
   localparam char_t CH_2     = 5'd2;
   localparam char_t CH_3     = 5'd3;
   localparam char_t CH_4     = 5'd4;
   localparam char_t CH_5     = 5'd5;
   localparam char_t CH_6     = 5'd6;
   localparam char_t CH_7     = 5'd7;
   localparam char_t CH_8     = 5'd8;
   localparam char_t CH_9     = 5'd9;
   localparam char_t CH_A     = 5'd10;
   localparam char_t CH_C     = 5'd11;
   localparam char_t CH_E     = 5'd12;
   localparam char_t CH_F     = 5'd13;
   localparam char_t CH_L     = 5'd14;
   localparam char_t CH_P     = 5'd15;
   localparam char_t CH_U     = 5'd16;
   localparam char_t CH_DASH  = 5'd17;
   localparam char_t CH_BLANK = 5'd31;

   // Active-high segments {a,b,c,d,e,f,g}; polarity is applied at the pins.
   localparam logic [6:0] SEG_OFF = 7'h00;

   // Listed from code 31 down to code 0; codes 18..31 are dark.
   localparam logic [31:0][6:0] SEG_LUT = {
      {14{7'b0000000}},
      7'b0000001, 7'b0111110, 7'b1100111, 7'b0001110,  // -, U, P, L
      7'b1000111, 7'b1001111, 7'b1001110, 7'b1110111,  // F, E, C, A
      7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111,  // 9, 8, 7, 6
      7'b1011011, 7'b0110011, 7'b1111001, 7'b1101101,  // 5, 4, 3, 2
      7'b0110000, 7'b1111110                           // 1, 0
   };

   localparam int unsigned ROM_N_MSG   = 4;
   localparam int unsigned ROM_MSG_LEN = 8;
   localparam int unsigned ROM_MSG_W   = 2;
   localparam int unsigned ROM_POS_W   = 3;

   // Messages: 0 "CAFE    ", 1 "CC05    ", 2 "CUP 2   ", 3 "FULL----" (char 0 rightmost).
   localparam logic [ROM_N_MSG-1:0][ROM_MSG_LEN-1:0][4:0] MSG_ROM = {
      {CH_DASH, CH_DASH, CH_DASH, CH_DASH, CH_L, CH_L, CH_U, CH_F},
      {CH_BLANK, CH_BLANK, CH_BLANK, CH_2, CH_BLANK, CH_P, CH_U, CH_C},
      {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_5, CH_0, CH_C, CH_C},
      {CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_E, CH_F, CH_A, CH_C}
   };

   function automatic char_t msg_char(input int unsigned m, input int unsigned p);
      if (m < ROM_N_MSG && p < ROM_MSG_LEN)
         return MSG_ROM[m[ROM_MSG_W-1:0]][p[ROM_POS_W-1:0]];
      return CH_BLANK;
   endfunction

endpackage

// File: rtl/seg7_message_scanner_char_decoder.sv
// Combinational character-code to active-high segment pattern decoder.
module seg7_char_decoder
   import seg7_pkg::*;
(
   input  char_t      code,
   output logic [6:0] pattern
);

   assign pattern = SEG_LUT[code];

endmodule

// File: rtl/seg7_message_scanner.sv
// Time-multiplexed N-digit 7-segment driver that scans one digit per slot
// and optionally scrolls the selected ROM message to the left.
module seg7_message_scanner
   import seg7_pkg::*;
#(
   parameter int N_DIGITS      = 4,
   parameter int MSG_LEN       = 8,
   parameter int N_MSG         = 4,
   parameter int SCAN_DIV      = 50000,
   parameter int SCROLL_FRAMES = 100,
   parameter bit ACTIVE_LOW    = 1'b1,
   localparam int SEL_W        = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SEL_W-1:0]    sel,
   input  logic                scroll_en,
   input  logic                blank,
   output logic [6:0]          seg,
   output logic [N_DIGITS-1:0] an,
   output logic                frame_tick
);

   localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int OFF_W  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int POS_W  = $clog2(2 * MSG_LEN);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int FRM_W  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [SCAN_W-1:0]   SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DIG_W-1:0]    DIG_LAST  = DIG_W'(N_DIGITS - 1);
   localparam logic [OFF_W-1:0]    OFF_LAST  = OFF_W'(MSG_LEN - 1);
   localparam logic [FRM_W-1:0]    FRM_LAST  = FRM_W'(SCROLL_FRAMES - 1);
   localparam logic [POS_W-1:0]    POS_LEN   = POS_W'(MSG_LEN);
   localparam logic [6:0]          SEG_DARK  = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic [N_DIGITS-1:0] AN_DARK   = ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

   logic [SCAN_W-1:0]   scan_cnt;
   logic [DIG_W-1:0]    digit_idx;
   logic [OFF_W-1:0]    offset;
   logic [FRM_W-1:0]    frame_cnt;
   logic [SEL_W-1:0]    sel_q;
   logic                slot_end;
   logic                frame_end;
   logic                sel_changed;
   logic [POS_W-1:0]    pos_sum;
   logic [POS_W-1:0]    pos;
   char_t               code;
   logic [6:0]          pattern;
   logic [N_DIGITS-1:0] an_onehot;

   assign slot_end    = (scan_cnt == SCAN_LAST);
   assign frame_end   = slot_end && (digit_idx == DIG_LAST);
   assign sel_changed = (sel != sel_q);
   assign frame_tick  = frame_end;

   // The sum never exceeds 2*MSG_LEN-2, so one conditional subtract wraps it.
   always_comb begin
      pos_sum   = POS_W'(offset) + POS_W'(digit_idx);
      pos       = (pos_sum >= POS_LEN) ? (pos_sum - POS_LEN) : pos_sum;
      code      = (32'(sel) < N_MSG) ? msg_char(32'(sel), 32'(pos)) : CH_BLANK;
      an_onehot = N_DIGITS'(1) << digit_idx;
   end

   seg7_char_decoder u_decoder (
      .code    (code),
      .pattern (pattern)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         offset    <= '0;
         frame_cnt <= '0;
         sel_q     <= '0;
         seg       <= SEG_DARK;
         an        <= AN_DARK;
      end else begin
         scan_cnt <= slot_end ? '0 : scan_cnt + 1'b1;
         if (slot_end)
            digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + 1'b1;
         sel_q <= sel;

         // A message change restarts the scroll even on a scroll-step tick.
         if (!scroll_en || sel_changed) begin
            offset    <= '0;
            frame_cnt <= '0;
         end else if (frame_end) begin
            if (frame_cnt == FRM_LAST) begin
               frame_cnt <= '0;
               offset    <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
            end else begin
               frame_cnt <= frame_cnt + 1'b1;
            end
         end

         if (blank) begin
            seg <= SEG_DARK;
            an  <= AN_DARK;
         end else begin
            seg <= ACTIVE_LOW ? ~pattern : pattern;
            an  <= ACTIVE_LOW ? ~an_onehot : an_onehot;
         end
      end
   end

endmodule

// File: tb/tb_seg7_message_scanner.sv
// Directed bench for seg7_message_scanner with 4 digits, 4-cycle slots and
// 2-frame scroll steps; expected pin values go through a scoreboard queue.
module tb_seg7_message_scanner;

   logic       clk;
   logic       rst_n;
   logic [1:0] sel;
   logic       scroll_en;
   logic       blank;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_tick;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [11:0] exp_q[$];

   localparam logic [6:0] P_BL = 7'b0000000;
   localparam logic [6:0] P_C  = 7'b1001110;
   localparam logic [6:0] P_0  = 7'b1111110;
   localparam logic [6:0] P_5  = 7'b1011011;
   localparam logic [6:0] P_U  = 7'b0111110;
   localparam logic [6:0] P_P  = 7'b1100111;
   localparam logic [6:0] P_2  = 7'b1101101;

   seg7_message_scanner #(
      .N_DIGITS      (4),
      .MSG_LEN       (8),
      .N_MSG         (3),
      .SCAN_DIV      (4),
      .SCROLL_FRAMES (2),
      .ACTIVE_LOW    (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (sel),
      .scroll_en  (scroll_en),
      .blank      (blank),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog cyc=%0d expired before end of sequence", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) tick();
   endtask

   task automatic expect_out(input logic ft, input logic [3:0] a, input logic [6:0] s);
      exp_q.push_back({ft, a, s});
   endtask

   task automatic compare(input string tag);
      logic [11:0] obs;
      logic [11:0] exp_v;
      obs = {frame_tick, an, seg};
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
         end
      end
   endtask

   // Slot k (1-based after release) shows digit ((k-1)%16)/4; tick at slot 14.
   task automatic check_cycles(input string tag, input int n, input bit dark,
                               input logic [6:0] p0, input logic [6:0] p1,
                               input logic [6:0] p2, input logic [6:0] p3);
      logic [6:0] pats[4];
      logic [3:0] oh;
      int slot;
      int dg;
      pats = '{p0, p1, p2, p3};
      for (int i = 0; i < n; i++) begin
         slot = cyc % 16;
         dg   = slot / 4;
         oh   = 4'b0001 << dg;
         expect_out(slot == 14, dark ? 4'hF : ~oh, dark ? 7'h7F : ~pats[dg]);
         tick();
         compare(tag);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      sel       = 2'd1;
      scroll_en = 1'b0;
      blank     = 1'b0;
      repeat (3) @(negedge clk);
      expect_out(1'b0, 4'hF, 7'h7F);
      compare("reset_hold");

      rst_n = 1'b1;
      cyc   = 0;
      check_cycles("scan_static", 32, 1'b0, P_C, P_C, P_0, P_5);

      scroll_en = 1'b1;
      run_to(64);
      check_cycles("scroll_off1", 16, 1'b0, P_C, P_0, P_5, P_BL);
      run_to(256);
      check_cycles("scroll_off7", 16, 1'b0, P_BL, P_C, P_C, P_0);
      run_to(288);
      check_cycles("scroll_wrap", 16, 1'b0, P_C, P_C, P_0, P_5);
      run_to(384);
      check_cycles("scroll_off3", 16, 1'b0, P_5, P_BL, P_BL, P_BL);

      run_to(415);
      sel = 2'd2;
      tick();
      check_cycles("sel_switch", 32, 1'b0, P_C, P_U, P_P, P_BL);

      run_to(470);
      blank = 1'b1;
      check_cycles("blank", 26, 1'b1, P_BL, P_BL, P_BL, P_BL);
      blank = 1'b0;
      check_cycles("unblank", 16, 1'b0, P_P, P_BL, P_2, P_BL);

      sel = 2'd3;
      tick();
      check_cycles("sel_out_of_range", 31, 1'b0, P_BL, P_BL, P_BL, P_BL);

      sel = 2'd1;
      run_to(704);
      check_cycles("pre_reset_off5", 10, 1'b0, P_BL, P_BL, P_BL, P_C);

      #2 rst_n = 1'b0;
      #1;
      expect_out(1'b0, 4'hF, 7'h7F);
      compare("async_reset");
      repeat (2) @(negedge clk);
      expect_out(1'b0, 4'hF, 7'h7F);
      compare("reset_held");

      rst_n = 1'b1;
      cyc   = 0;
      check_cycles("post_reset", 16, 1'b0, P_C, P_C, P_0, P_5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
